seq_shift_add_multiplier: RTL

- Iterative unsigned 64x64 -> 128-bit multiplier for the datapath's MUL path.
- Sits directly around the existing 64-bit ripple-carry adder: feeds its A/B/C0 operands every cycle and consumes its S/C64 result.
- Computes one partial-product step per clock, so the single long adder chain is reused instead of building a 64-row array.
- The processor launches it with a start pulse and stalls until done.

---
 rtl/mul_pkg.sv | 14 +
 rtl/rippleCarryAdder.sv | 20 ++
 rtl/seq_shift_add_multiplier.sv | 103 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and FSM state encoding for the sequential multiplier.
//   MUL_WIDTH - operand width (fixed to the 64-bit adder instance)
//   MUL_CNT_W - iteration counter width
//   MUL_ITERS - partial-product steps per operation
package mul_pkg;
    localparam int MUL_WIDTH = 64;
    localparam int MUL_CNT_W = 7;
    localparam int MUL_ITERS = 64;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/rippleCarryAdder.sv
// rippleCarryAdder: 64-bit ripple-carry adder shared by the datapath.
//   a, b - 64-bit addends
//   c0   - carry in
//   s    - 64-bit sum
//   c64  - carry out of bit 63
module rippleCarryAdder (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c0,
    output logic [63:0] s,
    output logic        c64
);
    logic [64:0] c;
    assign c[0] = c0;
    for (genvar i = 0; i < 64; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign c64 = c[64];
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: iterative unsigned 64x64->128 shift-add multiplier.
//   clk          - rising-edge clock
//   reset        - synchronous active-high reset
//   start        - launch request, honoured only in IDLE
//   multiplicand - operand M, captured on accepted start
//   multiplier   - operand Q, captured on accepted start
//   busy         - high while iterating
//   done         - one-cycle completion pulse
//   product      - 128-bit result, held until overwritten by the next completion
// Optional: define SHIFT_ADD_MUL_EARLY_TERM_EN to finish as soon as all
// unprocessed multiplier bits are zero.
module seq_shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    state_t state, state_n;
    logic [WIDTH-1:0] acc, q, m, s, addend;
    logic [CNT_W-1:0] count;
    logic c64, last, early;
    logic [2*WIDTH-1:0] shifted, early_prod;

    assign addend = q[0] ? m : '0;

    rippleCarryAdder u_adder (
        .a(acc),
        .b(addend),
        .c0(1'b0),
        .s(s),
        .c64(c64)
    );

    // carry-out becomes the new MSB of acc; the sum's LSB drops into Q
    assign shifted = {c64, s, q[WIDTH-1:1]};
    assign last = count == CNT_W'(MUL_ITERS - 1);

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    logic [CNT_W:0] r;
    assign r = (CNT_W + 1)'(MUL_ITERS) - {1'b0, count};
    // Q still holds the 64-count unprocessed bits in its low end; when they are
    // all zero the remaining steps are pure shifts, so apply them at once
    assign early = (q & ({WIDTH{1'b1}} >> count)) == '0;
    assign early_prod = {acc, q} >> r;
`else
    assign early = 1'b0;
    assign early_prod = shifted;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? BUSY : IDLE;
            BUSY:    state_n = (last || early) ? DONE : BUSY;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = state == BUSY;
        done = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            count   <= '0;
            product <= '0;
        end else if (state == IDLE && start) begin
            m     <= multiplicand;
            q     <= multiplier;
            acc   <= '0;
            count <= '0;
        end else if (state == BUSY) begin
            if (early)
                product <= early_prod;
            else begin
                {acc, q} <= shifted;
                count    <= count + CNT_W'(1);
                if (last)
                    product <= shifted;
            end
        end
    end
endmodule
